// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a framed byte stream, writes big-endian words into imem,
// verifies the XOR checksum and then enables the core.
module imem_boot_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  system_ena,
    output logic                  load_error,
    output logic                  busy
);
    typedef enum logic [2:0] {S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_RUN, S_ERROR} state_t;
    localparam logic [16:0] CAP = 17'd1 << ADDR_WIDTH;

    state_t                r_state, w_next;
    logic [7:0]            r_len_hi, r_xor;
    logic [15:0]           r_len, r_wcnt;
    logic [1:0]            r_bidx;
    logic [31:0]           r_asm, r_wdata;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_ready, r_we, r_ena, r_err, r_busy;
    logic                  w_acc, w_last;
    logic [15:0]           w_len;

    assign w_acc  = rx_valid && r_ready;
    assign w_len  = {r_len_hi, rx_data};
    assign w_last = (r_bidx == 2'd3) && (r_wcnt == r_len - 16'd1);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_SYNC;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_acc) begin
            case (r_state)
                S_SYNC:   w_next = (rx_data == SYNC_BYTE) ? S_LEN_HI : S_SYNC;
                S_LEN_HI: w_next = S_LEN_LO;
                S_LEN_LO: w_next = ({1'b0, w_len} > CAP) ? S_ERROR : (w_len == 16'd0) ? S_CHECK : S_DATA;
                S_DATA:   w_next = w_last ? S_CHECK : S_DATA;
                S_CHECK:  w_next = (rx_data == r_xor) ? S_RUN : S_ERROR;
                default:  w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len_hi <= '0;
            r_len    <= '0;
            r_wcnt   <= '0;
            r_bidx   <= '0;
            r_xor    <= '0;
            r_asm    <= '0;
            r_wdata  <= '0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_ready  <= 1'b0;
            r_ena    <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_we    <= 1'b0;
            r_ready <= !(w_next inside {S_RUN, S_ERROR});
            r_busy  <= w_next inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK};
            r_ena   <= w_next == S_RUN;
            r_err   <= w_next == S_ERROR;
            if (w_acc && r_state == S_LEN_HI) r_len_hi <= rx_data;
            if (w_acc && r_state == S_LEN_LO) begin
                r_len  <= w_len;
                r_wcnt <= '0;
                r_bidx <= '0;
            end
            if (w_acc && r_state == S_DATA) begin
                r_asm  <= {r_asm[23:0], rx_data};
                r_xor  <= r_xor ^ rx_data;
                r_bidx <= r_bidx + 2'd1;
                // fourth byte completes the word; the 2-bit index wraps to 0 by itself
                if (r_bidx == 2'd3) begin
                    r_we    <= 1'b1;
                    r_addr  <= r_wcnt[ADDR_WIDTH-1:0];
                    r_wdata <= {r_asm[23:0], rx_data};
                    r_wcnt  <= r_wcnt + 16'd1;
                end
            end
        end
    end

    assign rx_ready   = r_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign system_ena = r_ena;
    assign load_error = r_err;
    assign busy       = r_busy;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: scoreboard bench; expected imem writes are queued as bytes are driven
// and popped when imem_we is seen. Uses ADDR_WIDTH=4 so overflow and full-fill are reachable.
module tb_imem_boot_loader;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready, imem_we, system_ena, load_error, busy;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [63:0]   exp_q[$];
    logic [31:0]   words[$];

    imem_boot_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) u_dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .system_ena(system_ena), .load_error(load_error), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we) begin
            if (exp_q.size() == 0) check("unexpected_we", 32'd1, 32'd0);
            else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("waddr", 32'(imem_addr), e[63:32]);
                check("wdata", imem_wdata, e[31:0]);
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gmax);
        int g, n;
        g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
        rx_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!rx_ready) check("ready_timeout", 32'd0, 32'd1);
        else begin @(posedge clk); #1; end
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        check("rst_ready", 32'(rx_ready), 0);
        check("rst_we",    32'(imem_we), 0);
        check("rst_addr",  32'(imem_addr), 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_ena",   32'(system_ena), 0);
        check("rst_err",   32'(load_error), 0);
        check("rst_busy",  32'(busy), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("sync_ready", 32'(rx_ready), 1);
    endtask

    // Sends a full frame built from words[0..len-1]; bad flips the checksum LSB.
    task automatic load(input logic [15:0] len, input logic bad, input int gmax);
        logic [7:0]  x;
        logic [31:0] w;
        logic        ok;
        x = 8'h00;
        send(8'hA5, gmax);
        check("busy_after_sync", 32'(busy), 1);
        send(len[15:8], gmax);
        send(len[7:0], gmax);
        if (len > 16'(1 << AW)) begin
            check("ovf_err",   32'(load_error), 1);
            check("ovf_ena",   32'(system_ena), 0);
            check("ovf_ready", 32'(rx_ready), 0);
            check("ovf_busy",  32'(busy), 0);
            return;
        end
        for (int i = 0; i < int'(len); i++) begin
            w = words[i];
            for (int k = 0; k < 4; k++) begin
                logic [7:0] d;
                d = w[31-8*k -: 8];
                x ^= d;
                if (k == 3) exp_q.push_back({32'(i), w});
                send(d, gmax);
            end
        end
        check("busy_pre_chk", 32'(busy), 1);
        check("ena_pre_chk",  32'(system_ena), 0);
        send(bad ? (x ^ 8'h01) : x, gmax);
        ok = !bad;
        check("ena",   32'(system_ena), 32'(ok));
        check("err",   32'(load_error), 32'(!ok));
        check("ready_after", 32'(rx_ready), 0);
        check("busy_after",  32'(busy), 0);
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rx_valid = 1'b0;
        check("term_ready", 32'(rx_ready), 0);
        check("term_ena",   32'(system_ena), 32'(ok));
        check("pending_writes", 32'(exp_q.size()), 0);
    endtask

    initial begin
        do_reset();
        words = '{32'h24080005, 32'hAC080000};
        load(16'd2, 1'b0, 0);

        do_reset();
        load(16'd2, 1'b1, 0);

        do_reset();
        send(8'h00, 0); check("garbage_busy0", 32'(busy), 0);
        send(8'hFF, 0); check("garbage_busy1", 32'(busy), 0);
        send(8'h5A, 0); check("garbage_busy2", 32'(busy), 0);
        load(16'd2, 1'b0, 0);

        do_reset();
        load(16'd0, 1'b0, 0);

        do_reset();
        load(16'h0011, 1'b0, 0);
        repeat (3) begin @(posedge clk); #1; end
        check("ovf_sticky", 32'(load_error), 1);

        do_reset();
        words.delete();
        for (int i = 0; i < 16; i++) words.push_back($urandom());
        load(16'd16, 1'b0, 0);

        do_reset();
        words = '{32'h24080005, 32'hAC080000};
        load(16'd2, 1'b0, 4);

        do_reset();
        load(16'd2, 1'b1, 3);

        do_reset();
        send(8'hA5, 0); send(8'h00, 0); send(8'h02, 0);
        send(8'h24, 0); send(8'h08, 0); send(8'h00, 0);
        do_reset();
        load(16'd2, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
